accum_ctrl: RTL and testbench
=============================

# accum_ctrl

Sequencer for a PE's floating-point accumulator (FPadd with a feedback register). It takes a start command with an operand count, clears the accumulator, and feeds operands from a valid/ready stream. Operands are paced so each one issues only after the previous sum has returned through the feedback loop. It then captures the final sum and presents it on a result handshake. It sits between the PE operand/multiplier stage and the accumulator, and owns that accumulator's enable and clear inputs.

## Interface
- LEN_W, 8: width of operand count `len`.
- LOOP_LAT, 2: accumulator loop latency in cycles.
  - Definition: if `acc_en` is high in cycle C, the updated sum is visible on `acc_q` in cycle C+LOOP_LAT.
  - Legal range is ≥1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- len  in  LEN_W  operand count for the job; sampled with `start`.
- abort  in  1  cancel the current job.
- busy  out  1  high whenever state ≠ IDLE.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when `in_valid && in_ready`.
- in_data  in  32  IEEE-754 single-precision operand.
- acc_en  out  1  accumulator add enable (registered).
- acc_clr  out  1  accumulator clear (registered).
- acc_data  out  32  operand to the accumulator (registered).
- acc_q  in  32  accumulator output.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when `res_valid && res_ready`.
- res_data  out  32  captured final sum; holds its value until the next capture.

## Operation
- States: IDLE, CLEAR, FETCH, ISSUE, WAIT, CAPT, DONE.
- IDLE
  - `in_ready`=0.
  - On `start`: latch `len` into the remaining counter `rem` and go to CLEAR.
- CLEAR
  - Lasts one cycle with `acc_clr`=1.
  - Then go to FETCH if `rem`≠0, otherwise go to CAPT.
- FETCH
  - `in_ready`=1.
  - On accept: `acc_data`<=`in_data`, `rem`<=`rem`−1, go to ISSUE.
  - Without `in_valid`: stay in FETCH indefinitely.
- ISSUE
  - Lasts one cycle with `acc_en`=1 and `acc_data` holding the operand.
  - Load the wait counter with LOOP_LAT−1. If that value is 0, skip WAIT.
- WAIT
  - Count down.
  - On expiry go to FETCH if `rem`≠0, otherwise go to CAPT.
- CAPT
  - One cycle; `res_data`<=`acc_q`. Then go to DONE.
- DONE
  - `res_valid`=1 until `res_ready`; then go to IDLE.
- `acc_en`, `acc_clr`, `in_ready` and `res_valid` are 0 in every state not listed for them above.
- `acc_data` holds its last value outside ISSUE.
- `start` is ignored when busy. `in_valid` is ignored outside FETCH.
- `abort` (any non-IDLE state, including DONE): next state IDLE, a one-cycle `acc_clr` pulse, `res_valid` drops, and `res_data` is unchanged. `abort` in IDLE has no effect.
- `rst` wins over `abort` and `start`. After reset:
  - state IDLE, `rem`=0;
  - `acc_en`=0, `acc_clr`=0, `acc_data`=0;
  - `res_valid`=0, `res_data`=0, `in_ready`=0, `busy`=0.
- Reset mid-job discards the job with no clear pulse; the accumulator's own reset covers its register.
- `len`=0: the result is the cleared accumulator value (+0.0, 32'h0000_0000).
- The block performs no arithmetic; FP rounding and exceptions belong to the accumulator.
- `rem` counts down to 0 and never wraps.

## Timing
- Let `start` be sampled high at the end of cycle S. Then CLEAR is cycle S+1 and the first FETCH is S+2.
- Operand throughput is one per LOOP_LAT+1 cycles when `in_valid` is held high. Accepts land at S+2+k·(LOOP_LAT+1).
- The last operand is accepted in cycle A. Then:
  - ISSUE at A+1;
  - CAPT at A+1+LOOP_LAT;
  - `res_valid` first high in cycle A+2+LOOP_LAT.
- `len`=0: CAPT at S+2, `res_valid` at S+3.
- The earliest new `start` is the cycle after the result handshake, once state is back in IDLE.

## Test plan
- LOOP_LAT=2, `len`=3, operands 1.0/2.0/3.0 (3F800000/40000000/40400000), `in_valid` always high, `start` at S
  - accepts at S+2, S+5, S+8;
  - `acc_en` at S+3, S+6, S+9;
  - `res_valid` at S+12 with `res_data`=40C00000 (6.0).
- `len`=0 → `acc_clr` at S+1, `res_valid` at S+3, `res_data`=00000000; `acc_en` never asserted.
- `len`=2 with `in_valid` low for 4 cycles before each operand → FETCH stalls; `acc_en` pulses exactly twice; result is the sum of the two operands.
- `res_ready` held low for 5 cycles in DONE, with a `start` pulse during them → `res_valid` and `res_data` stable; the `start` is ignored; return to IDLE only after `res_ready`.
- `abort` in WAIT after 1 of 4 operands → next cycle IDLE with `acc_clr`=1 for one cycle; `res_valid` stays 0; `res_data` keeps the previous result. A following `len`=1 job with 2.0 returns 40000000.
- `rst` asserted in FETCH mid-job → next cycle all outputs at their reset values, `busy`=0. A new `len`=1 job with 1.0 returns 3F800000.

Source files
------------

// File: rtl/accum_ctrl.sv
// accum_ctrl: paces operands into a feedback FP accumulator, then captures and returns the sum.
// One operand per LOOP_LAT+1 cycles; in_ready only in FETCH, res_valid held until res_ready.
module accum_ctrl #(
    parameter int LEN_W    = 8,
    parameter int LOOP_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             acc_en,
    output logic             acc_clr,
    output logic [31:0]      acc_data,
    input  logic [31:0]      acc_q,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data
);

    localparam int CNT_W = (LOOP_LAT > 1) ? $clog2(LOOP_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LOOP_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [31:0]      acc_data_q, acc_data_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             acc_en_q, acc_en_d;
    logic             acc_clr_q, acc_clr_d;
    logic             in_ready_q, in_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic             more;

    assign more = (rem_q != '0);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        wait_d     = wait_q;
        acc_data_d = acc_data_q;
        res_data_d = res_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = more ? S_FETCH : S_CAPT;
            S_FETCH: begin
                if (in_valid && in_ready_q) begin
                    acc_data_d = in_data;
                    rem_d      = more ? rem_q - LEN_W'(1) : rem_q;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d = WAIT_INIT;
                if (WAIT_INIT == '0) state_d = more ? S_FETCH : S_CAPT;
                else                 state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q <= CNT_W'(1)) state_d = more ? S_FETCH : S_CAPT;
                else                     wait_d  = wait_q - CNT_W'(1);
            end
            S_CAPT: begin
                res_data_d = acc_q;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops the job in any busy state and leaves the previous result intact.
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            acc_data_d = acc_data_q;
            res_data_d = res_data_q;
        end

        acc_clr_d   = (state_d == S_CLEAR) || (abort && state_q != S_IDLE);
        acc_en_d    = (state_d == S_ISSUE);
        in_ready_d  = (state_d == S_FETCH);
        res_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            wait_q      <= '0;
            acc_data_q  <= '0;
            res_data_q  <= '0;
            acc_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            wait_q      <= wait_d;
            acc_data_q  <= acc_data_d;
            res_data_q  <= res_data_d;
            acc_en_q    <= acc_en_d;
            acc_clr_q   <= acc_clr_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign acc_en    = acc_en_q;
    assign acc_clr   = acc_clr_q;
    assign acc_data  = acc_data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Scoreboard bench for accum_ctrl with a behavioural LOOP_LAT=2 feedback accumulator.
module tb_accum_ctrl;
    localparam int LEN_W    = 8;
    localparam int LOOP_LAT = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             acc_en;
    logic             acc_clr;
    logic [31:0]      acc_data;
    logic [31:0]      acc_q  = '0;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;

    logic [31:0] pend_d = '0;
    logic        pend_v = 1'b0;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_res = 0;

    logic [31:0] op_dat[$];
    int          op_gap[$];
    logic [31:0] exp_q[$];
    int          acc_cyc[$];
    int          en_cyc[$];
    int          clr_cyc[$];
    int          rv_cyc[$];

    accum_ctrl #(.LEN_W(LEN_W), .LOOP_LAT(LOOP_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .acc_en(acc_en), .acc_clr(acc_clr), .acc_data(acc_data), .acc_q(acc_q),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Accumulator: clear visible next cycle, an add issued in C visible in C+2.
    initial forever begin
        @(posedge clk);
        if (rst || acc_clr) begin
            acc_q  <= '0;
            pend_v <= 1'b0;
        end else begin
            if (pend_v) acc_q <= pend_d;
            pend_v <= acc_en;
            pend_d <= r2f(f2r(acc_q) + f2r(acc_data));
        end
    end

    // Operand feeder: op i is held off for op_gap[i] cycles, then offered until accepted.
    initial begin
        int gap_left;
        int loaded;
        gap_left = 0;
        loaded   = -1;
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (n_acc < op_dat.size()) begin
                if (loaded != n_acc) begin
                    loaded   = n_acc;
                    gap_left = op_gap[n_acc];
                end
                if (gap_left > 0) begin
                    gap_left--;
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    in_data  = op_dat[n_acc];
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Monitor: logs event cycles and checks each result handshake against the scoreboard.
    initial begin
        logic prev_rv;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                n_acc++;
            end
            if (acc_en)  en_cyc.push_back(cyc);
            if (acc_clr) clr_cyc.push_back(cyc);
            if (res_valid && !prev_rv) rv_cyc.push_back(cyc);
            prev_rv = res_valid;
            if (res_valid && res_ready) begin
                if (n_res < exp_q.size()) chk("sb_res", res_data, exp_q[n_res]);
                else                      chk("sb_extra", n_res, exp_q.size());
                n_res++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [31:0] d, input int gap);
        op_gap.push_back(gap);
        op_dat.push_back(d);
    endtask

    task automatic start_job(input int l, output int s);
        start = 1'b1;
        len   = LEN_W'(l);
        s     = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_res(input int n, input string name);
        int k;
        k = 0;
        while (n_res < n && k < 300) begin
            step();
            k++;
        end
        chk(name, n_res, n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({busy, in_ready, acc_en, acc_clr, res_valid}), 32'd0);
        chk({tag, "_acc_data"}, acc_data, 32'd0);
        chk({tag, "_res_data"}, res_data, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, ba, be, br, bc, a1, a2;
        logic [31:0] d0;
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; res_ready = 1'b1;
        repeat (3) step();
        chk_reset_outputs("rst");
        rst = 1'b0;
        step();

        // len=3, 1.0+2.0+3.0, operands always available
        ba = acc_cyc.size(); be = en_cyc.size(); br = rv_cyc.size();
        push_op(32'h3F80_0000, 0); push_op(32'h4000_0000, 0); push_op(32'h4040_0000, 0);
        exp_q.push_back(32'h40C0_0000);
        step();
        start_job(3, s);
        wait_res(1, "t1_done");
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1_accept%0d", k), qget(acc_cyc, ba + k), s + 2 + 3 * k);
            chk($sformatf("t1_acc_en%0d", k), qget(en_cyc, be + k), s + 3 + 3 * k);
        end
        chk("t1_n_acc_en", en_cyc.size() - be, 3);
        chk("t1_res_valid_cycle", qget(rv_cyc, br), s + 12);

        // len=0 returns the cleared accumulator
        be = en_cyc.size(); br = rv_cyc.size(); bc = clr_cyc.size();
        exp_q.push_back(32'h0000_0000);
        step();
        start_job(0, s);
        wait_res(2, "t2_done");
        chk("t2_clr_cycle", qget(clr_cyc, bc), s + 1);
        chk("t2_res_valid_cycle", qget(rv_cyc, br), s + 3);
        chk("t2_n_acc_en", en_cyc.size() - be, 0);

        // len=2 with operand gaps: 2.0+3.0
        be = en_cyc.size(); ba = acc_cyc.size();
        push_op(32'h4000_0000, 4); push_op(32'h4040_0000, 4);
        exp_q.push_back(32'h40A0_0000);
        step();
        start_job(2, s);
        wait_res(3, "t3_done");
        chk("t3_n_acc_en", en_cyc.size() - be, 2);
        a1 = qget(acc_cyc, ba); a2 = qget(acc_cyc, ba + 1);
        chk("t3_stalled", 32'((a2 - a1) > LOOP_LAT + 1), 32'd1);

        // result held under backpressure, start ignored while DONE
        res_ready = 1'b0;
        push_op(32'h4080_0000, 0);
        exp_q.push_back(32'h4080_0000);
        step();
        start_job(1, s);
        for (int k = 0; k < 50 && !res_valid; k++) step();
        chk("t4_res_valid_seen", 32'(res_valid), 32'd1);
        d0 = res_data;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_hold_valid%0d", i), 32'({res_valid, busy}), 32'd3);
            chk($sformatf("t4_hold_data%0d", i), res_data, d0);
            if (i == 1) begin start = 1'b1; len = LEN_W'(3); end
            if (i == 2) start = 1'b0;
            step();
        end
        res_ready = 1'b1;
        step();
        chk("t4_released", 32'({busy, res_valid}), 32'd0);
        chk("t4_n_res", n_res, 4);
        step();
        chk("t4_start_ignored", 32'(busy), 32'd0);

        // abort in WAIT after the first of four operands
        push_op(32'h3F80_0000, 0);
        step();
        start_job(4, s);
        while (cyc < s + 4) step();
        chk("t5_in_wait", 32'({busy, in_ready, acc_en}), 32'b100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_ctl", 32'({busy, acc_clr, res_valid}), 32'b010);
        chk("t5_abort_res_data", res_data, 32'h4080_0000);
        step();
        chk("t5_clr_one_cycle", 32'({busy, acc_clr}), 32'd0);
        push_op(32'h4000_0000, 0);
        exp_q.push_back(32'h4000_0000);
        step();
        start_job(1, s);
        wait_res(5, "t5_done");

        // reset while stalled in FETCH
        step();
        start_job(2, s);
        while (cyc < s + 2) step();
        chk("t6_in_fetch", 32'({busy, in_ready}), 32'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("t6_rst");
        push_op(32'h3F80_0000, 0);
        exp_q.push_back(32'h3F80_0000);
        step();
        start_job(1, s);
        wait_res(6, "t6_done");

        step();
        chk("sb_drain", n_res, exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
